dtlb_assoc: RTL

Parametrised set-associative data TLB for the load/store pipe, replacing the fixed 8-way/16-set DTLB.
- Translates VPN+ASID to a DATA_W translation payload with 1-cycle registered latency.
- Supports fill with true-LRU victim selection, single-entry invalidate, and a sequenced flush (all or per-ASID) driven by an internal FSM.
- Sits between AGU address generation and the dcache tag compare; refilled by the page walker.

---
 rtl/dtlb_assoc.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/dtlb_assoc.sv
// rtl/dtlb_assoc.sv - set-associative data TLB with true-LRU fill and sequenced flush
// Optional performance counters: define DTLB_ASSOC_PERFCNT_EN to add hit_cnt/miss_cnt.
module dtlb_assoc #(
    parameter int WAYS      = 8,
    parameter int SETS_LOG2 = 4,
    parameter int VPN_W     = 51,
    parameter int ASID_W    = 21,
    parameter int DATA_W    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lk_valid,
    input  logic [VPN_W-1:0]         lk_vpn,
    input  logic [ASID_W-1:0]        lk_asid,
    output logic                     lk_ready,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [$clog2(WAYS)-1:0]  resp_way,
    output logic [DATA_W-1:0]        resp_data,
    input  logic                     wr_valid,
    input  logic [VPN_W-1:0]         wr_vpn,
    input  logic [ASID_W-1:0]        wr_asid,
    input  logic                     wr_global,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     inv_valid,
    input  logic [VPN_W-1:0]         inv_vpn,
    input  logic [ASID_W-1:0]        inv_asid,
    input  logic                     flush_valid,
    input  logic                     flush_by_asid,
    input  logic [ASID_W-1:0]        flush_asid,
    output logic                     busy
`ifdef DTLB_ASSOC_PERFCNT_EN
    ,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
`endif
);

    localparam int SETS  = 1 << SETS_LOG2;
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [SETS_LOG2-1:0] LAST_SET = {SETS_LOG2{1'b1}};
    localparam logic [WAY_W-1:0]     AGE_MAX  = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH} state_t;

    state_t                 state, state_next;
    logic [SETS_LOG2-1:0]   cnt;
    logic                   fl_by_asid;
    logic [ASID_W-1:0]      fl_asid;

    logic [WAYS-1:0]        ent_valid  [SETS];
    logic [WAYS-1:0]        ent_global [SETS];
    logic [VPN_W-1:0]       ent_vpn    [SETS][WAYS];
    logic [ASID_W-1:0]      ent_asid   [SETS][WAYS];
    logic [DATA_W-1:0]      ent_data   [SETS][WAYS];
    logic [WAY_W-1:0]       ent_age    [SETS][WAYS];

    logic [SETS_LOG2-1:0]   lk_set, wr_set, inv_set;
    logic [WAYS-1:0]        lk_hit_vec, inv_hit_vec, wr_match_vec, wr_free_vec, wr_lru_vec;
    logic [WAY_W-1:0]       lk_way, inv_way, wr_match_way, wr_free_way, wr_lru_way, wr_tgt;
    logic                   lk_hit;
    logic [DATA_W-1:0]      lk_data;
    logic [WAY_W-1:0]       lk_age_new [WAYS];
    logic [WAY_W-1:0]       wr_age_new [WAYS];
    logic                   lk_acc, lk_promote, flush_acc, inv_en, wr_en;

    assign lk_set  = lk_vpn[SETS_LOG2-1:0];
    assign wr_set  = wr_vpn[SETS_LOG2-1:0];
    assign inv_set = inv_vpn[SETS_LOG2-1:0];

    // Per-way tag compares for lookup, invalidate and fill; a global on either side
    // counts as a fill match so one VPN never lives twice under overlapping ASIDs.
    always_comb begin
        lk_hit_vec   = '0;
        inv_hit_vec  = '0;
        wr_match_vec = '0;
        wr_free_vec  = '0;
        wr_lru_vec   = '0;
        for (int w = 0; w < WAYS; w++) begin
            lk_hit_vec[w]   = ent_valid[lk_set][w] && (ent_vpn[lk_set][w] == lk_vpn) &&
                              (ent_global[lk_set][w] || (ent_asid[lk_set][w] == lk_asid));
            inv_hit_vec[w]  = ent_valid[inv_set][w] && (ent_vpn[inv_set][w] == inv_vpn) &&
                              (ent_global[inv_set][w] || (ent_asid[inv_set][w] == inv_asid));
            wr_match_vec[w] = ent_valid[wr_set][w] && (ent_vpn[wr_set][w] == wr_vpn) &&
                              (ent_global[wr_set][w] || wr_global ||
                               (ent_asid[wr_set][w] == wr_asid));
            wr_free_vec[w]  = !ent_valid[wr_set][w];
            wr_lru_vec[w]   = (ent_age[wr_set][w] == '0);
        end
    end

    // Lowest-index priority encoders over the compare vectors.
    always_comb begin
        lk_way       = '0;
        inv_way      = '0;
        wr_match_way = '0;
        wr_free_way  = '0;
        wr_lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_hit_vec[w])   lk_way       = WAY_W'(w);
            if (inv_hit_vec[w])  inv_way      = WAY_W'(w);
            if (wr_match_vec[w]) wr_match_way = WAY_W'(w);
            if (wr_free_vec[w])  wr_free_way  = WAY_W'(w);
            if (wr_lru_vec[w])   wr_lru_way   = WAY_W'(w);
        end
    end

    // Fill target selection and the promoted age vectors for both promotion sources.
    always_comb begin
        lk_hit  = |lk_hit_vec;
        lk_data = ent_data[lk_set][lk_way];
        if (|wr_match_vec)     wr_tgt = wr_match_way;
        else if (|wr_free_vec) wr_tgt = wr_free_way;
        else                   wr_tgt = wr_lru_way;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == lk_way)
                lk_age_new[w] = AGE_MAX;
            else if (ent_age[lk_set][w] > ent_age[lk_set][lk_way])
                lk_age_new[w] = ent_age[lk_set][w] - 1'b1;
            else
                lk_age_new[w] = ent_age[lk_set][w];
            if (WAY_W'(w) == wr_tgt)
                wr_age_new[w] = AGE_MAX;
            else if (ent_age[wr_set][w] > ent_age[wr_set][wr_tgt])
                wr_age_new[w] = ent_age[wr_set][w] - 1'b1;
            else
                wr_age_new[w] = ent_age[wr_set][w];
        end
    end

    // Ready/busy outputs decoded from the FSM state.
    always_comb begin
        lk_ready = (state == ST_IDLE);
        wr_ready = (state == ST_IDLE) && !inv_valid && !flush_valid;
        busy     = (state != ST_IDLE);
    end

    assign lk_acc     = lk_valid && (state == ST_IDLE);
    assign flush_acc  = flush_valid && (state == ST_IDLE);
    assign inv_en     = inv_valid && !flush_valid && (state == ST_IDLE);
    assign wr_en      = wr_valid && wr_ready;
    assign lk_promote = lk_acc && lk_hit && !(wr_en && (wr_set == lk_set));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_next;
    end

    // FSM next-state: INIT and FLUSH each walk every set once.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  if (cnt == LAST_SET) state_next = ST_IDLE;
            ST_IDLE:  if (flush_valid)     state_next = ST_FLUSH;
            ST_FLUSH: if (cnt == LAST_SET) state_next = ST_IDLE;
            default:  state_next = ST_INIT;
        endcase
    end

    // Set walker counter and latched flush qualifiers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            fl_by_asid <= 1'b0;
            fl_asid    <= '0;
        end else if (flush_acc) begin
            cnt        <= '0;
            fl_by_asid <= flush_by_asid;
            fl_asid    <= flush_asid;
        end else if (state != ST_IDLE) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Entry and age array updates; the fill's promotion is written last so it wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (state)
                ST_INIT: begin
                    ent_valid[cnt] <= '0;
                    for (int w = 0; w < WAYS; w++) ent_age[cnt][w] <= WAY_W'(w);
                end
                ST_IDLE: begin
                    if (lk_promote)
                        for (int w = 0; w < WAYS; w++) ent_age[lk_set][w] <= lk_age_new[w];
                    if (inv_en && (|inv_hit_vec))
                        ent_valid[inv_set][inv_way] <= 1'b0;
                    if (wr_en) begin
                        ent_valid[wr_set][wr_tgt]  <= 1'b1;
                        ent_global[wr_set][wr_tgt] <= wr_global;
                        ent_vpn[wr_set][wr_tgt]    <= wr_vpn;
                        ent_asid[wr_set][wr_tgt]   <= wr_asid;
                        ent_data[wr_set][wr_tgt]   <= wr_data;
                        for (int w = 0; w < WAYS; w++) ent_age[wr_set][w] <= wr_age_new[w];
                    end
                end
                ST_FLUSH: begin
                    for (int w = 0; w < WAYS; w++)
                        if (!fl_by_asid || (!ent_global[cnt][w] && (ent_asid[cnt][w] == fl_asid)))
                            ent_valid[cnt][w] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Registered lookup response; misses and idle cycles return zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= lk_acc;
            resp_hit   <= lk_acc && lk_hit;
            resp_way   <= (lk_acc && lk_hit) ? lk_way : '0;
            resp_data  <= (lk_acc && lk_hit) ? lk_data : '0;
        end
    end

`ifdef DTLB_ASSOC_PERFCNT_EN
    // Saturating hit/miss counters over delivered responses.
    always_ff @(posedge clk) begin
        if (rst || flush_acc) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (resp_valid) begin
            if (resp_hit && (hit_cnt != 32'hFFFF_FFFF))   hit_cnt  <= hit_cnt + 1'b1;
            if (!resp_hit && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule
